edp_muldiv_seq: RTL and testbench
=================================

# edp_muldiv_seq

Step sequencer for EBOX data-path (EDP) multiply and divide. While a multiply or divide is in progress it drives the AD function, ADA/ADB selects, the AR/ARX/MQ mux selects and the load strobes, one step per EDP clock. It reads MQ low bits, the AD sign and the AD carry-out back from EDP to make each step's decision. It sits between CTL and EDP and, while busy, overrides the microcode-sourced controls through CTL's mux.

## Interface
Parameters:
- `MUL_STEPS`, default 18: radix-4 Booth steps per multiply, for a 36-bit multiplier.
- `DIV_STEPS`, default 36: non-restoring divide steps.

Ports:
- `clk` in 1: EDP clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `start` in 1: request a new operation; sampled only in IDLE.
- `op_div` in 1: 0 selects multiply, 1 selects divide; sampled together with `start`.
- `abort` in 1: synchronous cancel.
- `mq_lo` in 2: MQ[34:35].
- `ad_sign` in 1: AD[0].
- `ad_cry` in 1: AD carry-out, AD_CRY[-2].
- `ad_op` out 6: CRAM.AD-format function code.
- `ada_sel` out 3: CRAM.ADA-format select.
- `adb_sel` out 2: CRAM.ADB-format select.
- `arl_sel` out 3: ARL mux select.
- `arr_sel` out 3: ARR mux select.
- `ar_load` out 1: load strobe for all three AR fields.
- `arx_load` out 1: ARX load strobe.
- `mqm_sel` out 2: MQM mux select.
- `mq_sel` out 2: MQ shift-register mode.
- `busy` out 1: sequencer owns the EDP controls.
- `done` out 1: one-cycle completion pulse.
- `ovf` out 1: divide overflow, valid while `done` is high.
- `err` out 1: one-cycle pulse on an unsupported request.

## Operation
- States are IDLE, SETUP, MSTEP, DCHK, DSTEP, FIXUP, DONE.
- IDLE:
  - Outputs take their defaults: `ad_op`=AD_A, all loads 0, `mq_sel`=MQ_HOLD.
  - `busy`=0.
  - `start`=1 moves to SETUP.
- SETUP:
  - Clear AR through ARL/ARR clear selects and assert `ar_load`.
  - Clear the Booth carry `bc`.
  - Load the step counter `cnt` (6 bits) with MUL_STEPS-1 or DIV_STEPS-1.
  - Next state is MSTEP for multiply, DCHK for divide.
- MSTEP:
  - Decode {mq_lo[0], mq_lo[1], bc}:
    - 000 and 111: AD_A.
    - 001 and 010: AD_APB with adb=BR.
    - 011: AD_APB with adb=BR×2.
    - 100: AD_AMB with adb=BR×2.
    - 101 and 110: AD_AMB with adb=BR.
  - AR loads AD shifted right 2 (arl_sel=3'b111, arr_sel=3'b111, `ar_load`=1).
  - MQ takes mqm_sel=2'b00 with `mq_sel`=MQ_LOAD, so ADX[34:35] shift into MQ.
  - `bc` <= mq_lo[0].
  - `cnt` decrements; when `cnt`==0, go to FIXUP.
- DCHK:
  - Drive AD_AMB with adb=BR.
  - If `ad_cry`=1 (AR ≥ BR), set `ovf` and go to DONE with no register loads.
  - Otherwise go to DSTEP.
- DSTEP:
  - Drive AD_AMB if the previous AD sign register `ps`=0, else AD_APB.
  - AR/ARX load AD/ADX shifted left 1 (arl_sel=3'b101, arr_sel=3'b101); `ar_load`=`arx_load`=1.
  - MQ shifts left (`mq_sel`=MQ_SHL) with quotient bit ~`ad_sign`.
  - `ps` <= `ad_sign`.
  - `cnt` decrements; when `cnt`==0, go to FIXUP.
- FIXUP:
  - Multiply: no-op cycle that lets the final AR settle.
  - Divide: if `ps`=1, drive AD_APB and load AR (remainder restore); otherwise AD_A with no load.
  - Next state is DONE.
- DONE: `done`=1 for one cycle, then IDLE. `busy` stays 1 through DONE.
- `abort` in any non-IDLE state:
  - Next state is IDLE and all outputs return to defaults.
  - No `done`; partial register contents are left undefined.
  - `abort` has priority over the state's own transition.
- `start` is ignored while `busy`=1. `start` together with `abort` in IDLE: `abort` wins and the request is dropped.

## Timing
- Reset (`reset_n`=0 at a clk edge): state IDLE; `cnt`, `bc`, `ps`, `ovf` cleared; every output at its IDLE default, and `done`/`err`=0.
- All outputs are registered-state decodes. Control becomes valid one cycle after the state transition, and EDP registers load at the next edge.
- Multiply latency: `start` sampled at edge 0, `done` high in cycle 1+1+MUL_STEPS+1 = 21 with defaults.
- Divide latency: 1+1+1+DIV_STEPS+1 = 40 cycles. Overflow path: `done` in cycle 3 with `ovf`=1.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- `cnt` never wraps: it reaches 0 exactly on the last step. A parameter value of 1 gives a single step.

## Configuration
- `EDP_MULDIV_DIV_EN` defined: divide path (DCHK, DSTEP, divide FIXUP, `ps`, `ovf`) is present.
- `EDP_MULDIV_DIV_EN` undefined:
  - Divide states are not compiled.
  - `start` with `op_div`=1 pulses `err` for one cycle and stays in IDLE.
  - `ovf` is tied to 0.

## Structure
- Package `edp_muldiv_pkg` contains:
  - State enum.
  - AD codes: AD_A=6'b000000, AD_APB=6'b001001, AD_AMB=6'b100110.
  - ADB codes: ADB_BR=2'b10, ADB_BRX2=2'b01.
  - MQ modes: MQ_LOAD=2'b00, MQ_SHR=2'b01, MQ_SHL=2'b10, MQ_HOLD=2'b11.
- One sub-module, `booth_dec`, maps the 3-bit Booth window to {ad_op, adb_sel}. It is purely combinational.

## Test plan
- Reset mid-MSTEP (cnt=7) -> next cycle IDLE, `busy`=0, `mq_sel`=2'b11, no `done`.
- Multiply with mq_lo=2'b01 and bc=0 on the first step -> `ad_op`=6'b001001, `adb_sel`=2'b10. `done` arrives exactly 21 cycles after `start` and `busy` falls the next cycle.
- Booth window 100 -> `ad_op`=6'b100110, `adb_sel`=2'b01; window 111 -> `ad_op`=0, `adb_sel` don't-care.
- Divide with `ad_cry`=1 in DCHK -> `done`+`ovf` in cycle 3, `ar_load` never asserted.
- Normal divide with ad_sign=1 on the last step -> FIXUP drives AD_APB with `ar_load`=1, and `done` at cycle 40.
- `abort` at DSTEP step 10 with simultaneous `start` -> IDLE and the `start` is ignored. A fresh `start` the following cycle is accepted. Without EDP_MULDIV_DIV_EN, a divide `start` yields a one-cycle `err` and `busy` stays 0.

Source files
------------

// File: rtl/edp_muldiv_pkg.sv
// Shared types and CRAM-format encodings for the EDP multiply/divide step sequencer.
package edp_muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_MSTEP,
    ST_DCHK,
    ST_DSTEP,
    ST_FIXUP,
    ST_DONE
  } state_t;

  localparam logic [5:0] AD_A   = 6'b000000;
  localparam logic [5:0] AD_APB = 6'b001001;
  localparam logic [5:0] AD_AMB = 6'b100110;

  localparam logic [2:0] ADA_AR   = 3'b000;
  localparam logic [1:0] ADB_FM   = 2'b00;
  localparam logic [1:0] ADB_BRX2 = 2'b01;
  localparam logic [1:0] ADB_BR   = 2'b10;

  // AR half-word mux selects: straight AD, clear, AD*2 (with ADX), AD/4 (into ADX)
  localparam logic [2:0] AR_SEL_AD   = 3'b000;
  localparam logic [2:0] AR_SEL_CLR  = 3'b100;
  localparam logic [2:0] AR_SEL_SHL1 = 3'b101;
  localparam logic [2:0] AR_SEL_SHR2 = 3'b111;

  localparam logic [1:0] MQM_ADX = 2'b00;

  localparam logic [1:0] MQ_LOAD = 2'b00;
  localparam logic [1:0] MQ_SHR  = 2'b01;
  localparam logic [1:0] MQ_SHL  = 2'b10;
  localparam logic [1:0] MQ_HOLD = 2'b11;

endpackage

// File: rtl/edp_muldiv_seq_booth_dec.sv
// Radix-4 Booth window {MQ34, MQ35, carry} to AD function and ADB select; combinational.
module booth_dec
  import edp_muldiv_pkg::*;
(
  input  logic [2:0] win,
  output logic [5:0] ad_op,
  output logic [1:0] adb_sel
);

  always_comb begin
    ad_op   = AD_A;
    adb_sel = ADB_FM;
    case (win)
      3'b001, 3'b010: begin ad_op = AD_APB; adb_sel = ADB_BR;   end
      3'b011:         begin ad_op = AD_APB; adb_sel = ADB_BRX2; end
      3'b100:         begin ad_op = AD_AMB; adb_sel = ADB_BRX2; end
      3'b101, 3'b110: begin ad_op = AD_AMB; adb_sel = ADB_BR;   end
      default: ;
    endcase
  end

endmodule

// File: rtl/edp_muldiv_seq.sv
// EDP multiply/divide step sequencer; overrides CTL controls while busy, one step per clock.
// Divide path (DCHK/DSTEP, remainder fixup, ovf) is compiled only with EDP_MULDIV_DIV_EN.
module edp_muldiv_seq
  import edp_muldiv_pkg::*;
#(
  parameter int MUL_STEPS = 18,
  parameter int DIV_STEPS = 36
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       op_div,
  input  logic       abort,
  input  logic [0:1] mq_lo,
  input  logic       ad_sign,
  input  logic       ad_cry,
  output logic [5:0] ad_op,
  output logic [2:0] ada_sel,
  output logic [1:0] adb_sel,
  output logic [2:0] arl_sel,
  output logic [2:0] arr_sel,
  output logic       ar_load,
  output logic       arx_load,
  output logic [1:0] mqm_sel,
  output logic [1:0] mq_sel,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       err
);

  localparam logic [5:0] MUL_LAST = 6'(MUL_STEPS - 1);

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       bc_q, bc_d;
  logic       err_q, err_d;
  logic [5:0] booth_ad_op;
  logic [1:0] booth_adb_sel;

`ifdef EDP_MULDIV_DIV_EN
  localparam logic [5:0] DIV_LAST = 6'(DIV_STEPS - 1);
  logic op_q, op_d;
  logic ps_q, ps_d;
  logic ovf_q, ovf_d;
`else
  logic unused_div_in;
  assign unused_div_in = ad_sign ^ ad_cry;
`endif

  booth_dec u_booth_dec (
    .win     ({mq_lo[0], mq_lo[1], bc_q}),
    .ad_op   (booth_ad_op),
    .adb_sel (booth_adb_sel)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bc_d     = bc_q;
    err_d    = 1'b0;
    ad_op    = AD_A;
    ada_sel  = ADA_AR;
    adb_sel  = ADB_FM;
    arl_sel  = AR_SEL_AD;
    arr_sel  = AR_SEL_AD;
    ar_load  = 1'b0;
    arx_load = 1'b0;
    mqm_sel  = MQM_ADX;
    mq_sel   = MQ_HOLD;
    done     = 1'b0;
    busy     = (state_q != ST_IDLE);
`ifdef EDP_MULDIV_DIV_EN
    op_d  = op_q;
    ps_d  = ps_q;
    ovf_d = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
`ifdef EDP_MULDIV_DIV_EN
          op_d    = op_div;
          state_d = ST_SETUP;
`else
          if (op_div) err_d = 1'b1;
          else        state_d = ST_SETUP;
`endif
        end
      end

      ST_SETUP: begin
        arl_sel = AR_SEL_CLR;
        arr_sel = AR_SEL_CLR;
        ar_load = 1'b1;
        bc_d    = 1'b0;
`ifdef EDP_MULDIV_DIV_EN
        ps_d    = 1'b0;
        ovf_d   = 1'b0;
        cnt_d   = op_q ? DIV_LAST : MUL_LAST;
        state_d = op_q ? ST_DCHK : ST_MSTEP;
`else
        cnt_d   = MUL_LAST;
        state_d = ST_MSTEP;
`endif
      end

      ST_MSTEP: begin
        ad_op   = booth_ad_op;
        adb_sel = booth_adb_sel;
        arl_sel = AR_SEL_SHR2;
        arr_sel = AR_SEL_SHR2;
        ar_load = 1'b1;
        mqm_sel = MQM_ADX;
        mq_sel  = MQ_LOAD;
        bc_d    = mq_lo[0];
        if (cnt_q == 6'd0) state_d = ST_FIXUP;
        else               cnt_d   = cnt_q - 6'd1;
      end

`ifdef EDP_MULDIV_DIV_EN
      // Trial subtract of BR from the high half: no borrow means the quotient won't fit.
      ST_DCHK: begin
        ad_op   = AD_AMB;
        adb_sel = ADB_BR;
        if (ad_cry) begin
          ovf_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_DSTEP;
        end
      end

      ST_DSTEP: begin
        ad_op    = ps_q ? AD_APB : AD_AMB;
        adb_sel  = ADB_BR;
        arl_sel  = AR_SEL_SHL1;
        arr_sel  = AR_SEL_SHL1;
        ar_load  = 1'b1;
        arx_load = 1'b1;
        // MQM upper bit selects the quotient shift-in, lower bit carries its value
        mqm_sel  = {1'b1, ~ad_sign};
        mq_sel   = MQ_SHL;
        ps_d     = ad_sign;
        if (cnt_q == 6'd0) state_d = ST_FIXUP;
        else               cnt_d   = cnt_q - 6'd1;
      end
`endif

      ST_FIXUP: begin
`ifdef EDP_MULDIV_DIV_EN
        if (op_q && ps_q) begin
          ad_op   = AD_APB;
          adb_sel = ADB_BR;
          ar_load = 1'b1;
        end
`endif
        state_d = ST_DONE;
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
`ifdef EDP_MULDIV_DIV_EN
      ovf_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      bc_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef EDP_MULDIV_DIV_EN
      op_q    <= 1'b0;
      ps_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      err_q   <= err_d;
`ifdef EDP_MULDIV_DIV_EN
      op_q    <= op_d;
      ps_q    <= ps_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign err = err_q;
`ifdef EDP_MULDIV_DIV_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// Bench for edp_muldiv_seq: directed stimulus, expected done/err responses queued and
// checked by an independent monitor; step-level control outputs checked inline.
module tb_edp_muldiv_seq;
  import edp_muldiv_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, start, op_div, abort, ad_sign, ad_cry;
  logic [0:1] mq_lo;
  logic [5:0] ad_op;
  logic [2:0] ada_sel, arl_sel, arr_sel;
  logic [1:0] adb_sel, mqm_sel, mq_sel;
  logic       ar_load, arx_load, busy, done, ovf, err;

  edp_muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_div(op_div), .abort(abort),
    .mq_lo(mq_lo), .ad_sign(ad_sign), .ad_cry(ad_cry),
    .ad_op(ad_op), .ada_sel(ada_sel), .adb_sel(adb_sel), .arl_sel(arl_sel),
    .arr_sel(arr_sel), .ar_load(ar_load), .arx_load(arx_load), .mqm_sel(mqm_sel),
    .mq_sel(mq_sel), .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit is_err;
    bit ovf;
    int cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Called at a falling edge before the start edge; lat counts rising edges from start.
  task automatic push(input bit is_err, input bit o, input int lat);
    exp_t e;
    e.is_err = is_err;
    e.ovf    = o;
    e.cyc    = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name, input int lim);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_done_seen"}, done, 1);
  endtask

  always @(negedge clk) begin
    #1;
    if (reset_n === 1'b1 && (done === 1'b1 || err === 1'b1)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: done=%0b err=%0b, want no response", done, err);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_kind", {30'd0, done, err}, mon_e.is_err ? 32'd1 : 32'd2);
        chk("resp_cycle", cyc, mon_e.cyc);
        if (!mon_e.is_err) chk("resp_ovf", ovf, mon_e.ovf);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op_div = 1'b0; abort = 1'b0;
    mq_lo = 2'b00; ad_sign = 1'b0; ad_cry = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ad_op", ad_op, AD_A);
    chk("rst_mq_sel", mq_sel, MQ_HOLD);
    chk("rst_loads", {ar_load, arx_load}, 0);
    reset_n = 1'b1;

    // Multiply with Booth window checks on the first four steps
    @(negedge clk); start = 1'b1; op_div = 1'b0; push(0, 0, 21);
    @(negedge clk); start = 1'b0; #1;
    chk("setup_busy", busy, 1);
    chk("setup_ar_load", ar_load, 1);
    chk("setup_arl_sel", arl_sel, AR_SEL_CLR);
    @(negedge clk); mq_lo = 2'b01; #1;
    chk("m1_ad_op", ad_op, AD_APB);
    chk("m1_adb_sel", adb_sel, ADB_BR);
    chk("m1_arl_sel", arl_sel, 3'b111);
    chk("m1_mq_sel", mq_sel, MQ_LOAD);
    chk("m1_ar_load", ar_load, 1);
    @(negedge clk); mq_lo = 2'b10; #1;
    chk("m2_ad_op", ad_op, AD_AMB);
    chk("m2_adb_sel", adb_sel, ADB_BRX2);
    @(negedge clk); mq_lo = 2'b11; #1;
    chk("m3_ad_op", ad_op, AD_A);
    @(negedge clk); mq_lo = 2'b01; #1;
    chk("m4_ad_op", ad_op, AD_APB);
    chk("m4_adb_sel", adb_sel, ADB_BRX2);
    mq_lo = 2'b00;
    wait_done("mul", 40);
    chk("mul_busy_at_done", busy, 1);
    @(negedge clk); #1;
    chk("mul_busy_after", busy, 0);

    // Reset in the middle of a multiply (cnt=7)
    @(negedge clk); start = 1'b1; op_div = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    chk("rm_busy_before", busy, 1);
    reset_n = 1'b0;
    @(negedge clk); #1;
    chk("rm_busy", busy, 0);
    chk("rm_mq_sel", mq_sel, MQ_HOLD);
    chk("rm_done", done, 0);
    reset_n = 1'b1;

    // start with abort in IDLE is dropped
    @(negedge clk); start = 1'b1; abort = 1'b1; op_div = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0; op_div = 1'b0; #1;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_err", err, 0);

`ifdef EDP_MULDIV_DIV_EN
    // Divide overflow
    @(negedge clk); start = 1'b1; op_div = 1'b1; ad_cry = 1'b1; push(0, 1, 3);
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
    chk("dchk_ad_op", ad_op, AD_AMB);
    chk("dchk_adb_sel", adb_sel, ADB_BR);
    chk("dchk_ar_load", ar_load, 0);
    @(negedge clk); #1;
    chk("ovf_done_ar_load", ar_load, 0);
    ad_cry = 1'b0;
    @(negedge clk); #1;
    chk("ovf_busy_after", busy, 0);

    // Normal divide, negative partial remainder on the last step
    @(negedge clk); start = 1'b1; op_div = 1'b1; push(0, 0, 40);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); ad_sign = 1'b1; #1;
    chk("d1_ad_op", ad_op, AD_AMB);
    chk("d1_loads", {ar_load, arx_load}, 2'b11);
    chk("d1_arl_sel", arl_sel, 3'b101);
    chk("d1_mq_sel", mq_sel, MQ_SHL);
    @(negedge clk); ad_sign = 1'b0; #1;
    chk("d2_ad_op", ad_op, AD_APB);
    repeat (34) @(negedge clk);
    ad_sign = 1'b1; #1;
    chk("dlast_ad_op", ad_op, AD_AMB);
    @(negedge clk); ad_sign = 1'b0; #1;
    chk("fix_ad_op", ad_op, AD_APB);
    chk("fix_ar_load", ar_load, 1);
    wait_done("div", 5);
    @(negedge clk); #1;
    chk("div_busy_after", busy, 0);

    // Abort at divide step 10 with a simultaneous start, then a fresh multiply
    @(negedge clk); start = 1'b1; op_div = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    chk("ab_busy_before", busy, 1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0; #1;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
`else
    // Divide request rejected when the divide path is not built
    @(negedge clk); start = 1'b1; op_div = 1'b1; push(1, 0, 1);
    @(negedge clk); start = 1'b0; op_div = 1'b0; #1;
    chk("div_rej_err", err, 1);
    chk("div_rej_busy", busy, 0);
    @(negedge clk); #1;
    chk("div_rej_err_clr", err, 0);
    chk("div_rej_busy2", busy, 0);

    // Abort mid-multiply with a simultaneous start, then a fresh multiply
    @(negedge clk); start = 1'b1; op_div = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    chk("ab_busy_before", busy, 1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0; #1;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
`endif
    start = 1'b1; op_div = 1'b0; push(0, 0, 21);
    @(negedge clk); start = 1'b0; #1;
    chk("fresh_busy", busy, 1);
    wait_done("fresh", 30);
    @(negedge clk); #1;
    chk("fresh_busy_after", busy, 0);

    repeat (3) @(negedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
